// File: rtl/scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } scan_state_e;

  localparam logic [7:0]  SEG_BLANK        = 8'h00;
  localparam int unsigned DEF_ON_CYCLES    = 100000;
  localparam int unsigned DEF_BLANK_CYCLES = 1000;

  // Digit index width; a single digit still gets a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 32'd1 : 32'($clog2(n));
  endfunction

  function automatic int unsigned timer_width(input int unsigned on_c,
                                              input int unsigned blank_c);
    int unsigned m;
    m = (on_c > blank_c) ? on_c : blank_c;
    return 32'($clog2(m + 1));
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter; terminal count when the count reaches zero.
module scan_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tc_c,
  output logic         o_tc_next_c
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_tc_c      = (r_count == '0);
  // Terminal count as it will be seen in the next cycle.
  assign o_tc_next_c = i_load ? (i_load_val == '0) : (r_count <= W'(1));

endmodule

// File: rtl/seg_decode.sv
// Hex nibble to seven-segment pattern {g,f,e,d,c,b,a}, active-high.
module seg_decode (
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg_c
);

  always_comb begin
    o_seg_c = 7'h00;
    case (i_nib)
      4'h0: o_seg_c = 7'h3F;
      4'h1: o_seg_c = 7'h06;
      4'h2: o_seg_c = 7'h5B;
      4'h3: o_seg_c = 7'h4F;
      4'h4: o_seg_c = 7'h66;
      4'h5: o_seg_c = 7'h6D;
      4'h6: o_seg_c = 7'h7D;
      4'h7: o_seg_c = 7'h07;
      4'h8: o_seg_c = 7'h7F;
      4'h9: o_seg_c = 7'h6F;
      4'hA: o_seg_c = 7'h77;
      4'hB: o_seg_c = 7'h7C;
      4'hC: o_seg_c = 7'h39;
      4'hD: o_seg_c = 7'h5E;
      4'hE: o_seg_c = 7'h79;
      4'hF: o_seg_c = 7'h71;
      default: o_seg_c = 7'h00;
    endcase
  end

endmodule

// File: rtl/scan_controller.sv
// Multiplexed seven-segment scanner with per-frame snapshot and blank gap.
// Optional leading-zero suppression under SCAN_LEADING_ZERO_BLANK_EN.
module scan_controller
  import scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned ON_CYCLES    = DEF_ON_CYCLES,
  parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                                CLK,
  input  logic                                RST_N,
  input  logic                                EN,
  input  logic [4*NUM_DIGITS-1:0]             DATA,
  input  logic [NUM_DIGITS-1:0]               DP_IN,
  output logic [NUM_DIGITS-1:0]               SCAN_OUT,
  output logic [7:0]                          SEG_OUT,
  output logic [idx_width(NUM_DIGITS)-1:0]    DIGIT_IDX,
  output logic                                FRAME_DONE
);

  localparam int unsigned IW         = idx_width(NUM_DIGITS);
  localparam int unsigned TW         = timer_width(ON_CYCLES, BLANK_CYCLES);
  localparam int unsigned ON_LOAD    = ON_CYCLES - 1;
  localparam int unsigned BLANK_LOAD = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
  localparam logic [IW-1:0]         LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL0     = NUM_DIGITS'(1);

  scan_state_e                 r_state, w_state_nxt;
  logic [IW-1:0]               r_idx, w_idx_nxt;
  logic [NUM_DIGITS-1:0][3:0]  r_snap_data, w_snap_data_nxt, w_data_v;
  logic [NUM_DIGITS-1:0]       r_snap_dp, w_snap_dp_nxt;
  logic [NUM_DIGITS-1:0]       r_scan;
  logic [7:0]                  r_seg, w_seg_nxt;
  logic                        r_frame_done, w_frame_done_nxt;
  logic                        w_capture, w_adv, w_load, w_tc, w_tc_nxt;
  logic [TW-1:0]               w_load_val;
  logic [3:0]                  w_nib;
  logic [6:0]                  w_dec;

  assign w_data_v = DATA;

  scan_timer #(.W(TW)) u_timer (
    .clk         (CLK),
    .rst_n       (RST_N),
    .i_load      (w_load),
    .i_load_val  (w_load_val),
    .o_tc_c      (w_tc),
    .o_tc_next_c (w_tc_nxt)
  );

  // Next state; the timer is reloaded on every state entry.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_capture   = 1'b0;
    w_adv       = 1'b0;
    w_load      = 1'b0;
    w_load_val  = '0;
    case (r_state)
      IDLE: begin
        if (EN) begin
          w_capture   = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = SHOW;
          w_load      = 1'b1;
          w_load_val  = TW'(ON_LOAD);
        end
      end
      SHOW: begin
        if (w_tc) begin
          if (BLANK_CYCLES != 0) begin
            w_state_nxt = BLANK;
            w_load      = 1'b1;
            w_load_val  = TW'(BLANK_LOAD);
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      BLANK: begin
        if (w_tc) w_adv = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_adv) begin
      w_load = 1'b1;
      if (r_idx != LAST_IDX) begin
        w_idx_nxt   = r_idx + IW'(1);
        w_state_nxt = SHOW;
        w_load_val  = TW'(ON_LOAD);
      end else if (EN) begin
        w_capture   = 1'b1;
        w_idx_nxt   = '0;
        w_state_nxt = SHOW;
        w_load_val  = TW'(ON_LOAD);
      end else begin
        w_state_nxt = IDLE;
        w_load_val  = '0;
      end
    end
  end

  assign w_snap_data_nxt = w_capture ? w_data_v : r_snap_data;
  assign w_snap_dp_nxt   = w_capture ? DP_IN : r_snap_dp;
  assign w_nib           = w_snap_data_nxt[w_idx_nxt];

  seg_decode u_decode (
    .i_nib   (w_nib),
    .o_seg_c (w_dec)
  );

`ifdef SCAN_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] r_supp, w_supp_in, w_supp_nxt;

  // A digit is blank only if it and every higher digit are zero with no DP.
  always_comb begin
    logic w_run;
    w_run     = 1'b1;
    w_supp_in = '0;
    for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
      w_run        = w_run && (w_data_v[i] == 4'h0) && !DP_IN[i];
      w_supp_in[i] = w_run;
    end
  end

  assign w_supp_nxt = w_capture ? w_supp_in : r_supp;
  assign w_seg_nxt  = w_supp_nxt[w_idx_nxt] ? SEG_BLANK
                                            : {w_snap_dp_nxt[w_idx_nxt], w_dec};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_supp <= '0;
    else        r_supp <= w_supp_nxt;
  end
`else
  assign w_seg_nxt = {w_snap_dp_nxt[w_idx_nxt], w_dec};
`endif

  assign w_frame_done_nxt = (w_idx_nxt == LAST_IDX) && w_tc_nxt &&
                            ((w_state_nxt == BLANK) ||
                             ((BLANK_CYCLES == 0) && (w_state_nxt == SHOW)));

  // Outputs are registered from next-state values so they track the state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_snap_data  <= '0;
      r_snap_dp    <= '0;
      r_scan       <= '0;
      r_seg        <= SEG_BLANK;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_snap_data  <= w_snap_data_nxt;
      r_snap_dp    <= w_snap_dp_nxt;
      r_scan       <= (w_state_nxt == SHOW) ? (SEL0 << w_idx_nxt) : '0;
      r_seg        <= (w_state_nxt == SHOW) ? w_seg_nxt : SEG_BLANK;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign SCAN_OUT   = r_scan;
  assign SEG_OUT    = r_seg;
  assign DIGIT_IDX  = r_idx;
  assign FRAME_DONE = r_frame_done;

endmodule

// File: tb/tb_scan_controller.sv
// Scoreboard bench for scan_controller (4 digits, ON=4, BLANK=1).
module tb_scan_controller;

  localparam int unsigned ND  = 4;
  localparam int unsigned ONC = 4;
  localparam int unsigned BLC = 1;

  logic        CLK   = 1'b0;
  logic        RST_N = 1'b0;
  logic        EN    = 1'b0;
  logic [15:0] DATA  = 16'h0000;
  logic [3:0]  DP_IN = 4'h0;
  logic [3:0]  SCAN_OUT;
  logic [7:0]  SEG_OUT;
  logic [1:0]  DIGIT_IDX;
  logic        FRAME_DONE;

  typedef struct packed {
    logic [3:0] scan;
    logic [7:0] seg;
    logic [1:0] idx;
    logic       fd;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  scan_controller #(
    .NUM_DIGITS   (ND),
    .ON_CYCLES    (ONC),
    .BLANK_CYCLES (BLC)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .EN         (EN),
    .DATA       (DATA),
    .DP_IN      (DP_IN),
    .SCAN_OUT   (SCAN_OUT),
    .SEG_OUT    (SEG_OUT),
    .DIGIT_IDX  (DIGIT_IDX),
    .FRAME_DONE (FRAME_DONE)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // segs[8k+:8] is the hand-decoded SEG_OUT expected while digit k is shown.
  task automatic push_frame(input logic [31:0] segs);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < int'(ONC); c++) begin
        e.scan = 4'b0001 << k;
        e.seg  = segs[8*k +: 8];
        e.idx  = 2'(k);
        e.fd   = 1'b0;
        sb_q.push_back(e);
      end
      e.scan = 4'b0000;
      e.seg  = 8'h00;
      e.idx  = 2'(k);
      e.fd   = (k == 3);
      sb_q.push_back(e);
    end
  endtask

  task automatic push_idle(input int n, input logic [1:0] idx);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.scan = 4'b0000;
      e.seg  = 8'h00;
      e.idx  = idx;
      e.fd   = 1'b0;
      sb_q.push_back(e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Monitor: compares each presented cycle against the next queued expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("scan_out",   32'(SCAN_OUT),   32'(e.scan));
      chk("seg_out",    32'(SEG_OUT),    32'(e.seg));
      chk("digit_idx",  32'(DIGIT_IDX),  32'(e.idx));
      chk("frame_done", 32'(FRAME_DONE), 32'(e.fd));
    end
  end

  localparam logic [31:0] SEGS_1234    = 32'h065B4F66;
  localparam logic [31:0] SEGS_ABCD    = 32'h777C395E;
  localparam logic [31:0] SEGS_1234_DP = 32'h06DB4F66;
`ifdef SCAN_LEADING_ZERO_BLANK_EN
  localparam logic [31:0] SEGS_0070    = 32'h0000073F;
`else
  localparam logic [31:0] SEGS_0070    = 32'h3F3F073F;
`endif

  initial begin
    #3;
    chk("rst_scan", 32'(SCAN_OUT), 32'h0);
    chk("rst_seg",  32'(SEG_OUT),  32'h0);
    chk("rst_idx",  32'(DIGIT_IDX), 32'h0);
    chk("rst_fd",   32'(FRAME_DONE), 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Basic scan, then a mid-frame DATA change that must wait for the next frame.
    step(1);
    push_idle(1, 2'd0);
    EN   = 1'b1;
    DATA = 16'h1234;
    step(1);
    push_frame(SEGS_1234);
    step(6);
    DATA = 16'hABCD;
    step(14);
    push_frame(SEGS_ABCD);

    // Disable mid-frame: frame completes, idles, then restarts one cycle after EN.
    step(9);
    EN = 1'b0;
    step(11);
    push_idle(1, 2'd3);
    step(1);
    EN    = 1'b1;
    DATA  = 16'h1234;
    DP_IN = 4'b0100;
    push_idle(1, 2'd3);
    step(1);
    push_frame(SEGS_1234_DP);

    // Leading zeros frame.
    step(3);
    DATA  = 16'h0070;
    DP_IN = 4'b0000;
    step(17);
    push_frame(SEGS_0070);

    // Async reset between edges during digit 2.
    step(11);
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_scan", 32'(SCAN_OUT), 32'h0);
    chk("async_seg",  32'(SEG_OUT),  32'h0);
    chk("async_idx",  32'(DIGIT_IDX), 32'h0);
    chk("async_fd",   32'(FRAME_DONE), 32'h0);
    sb_q.delete();
    @(posedge CLK);
    #1;
    chk("hold_scan", 32'(SCAN_OUT), 32'h0);
    chk("hold_seg",  32'(SEG_OUT),  32'h0);
    @(negedge CLK);
    #2;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    push_frame(SEGS_0070);
    step(5);
    EN = 1'b0;
    step(15);
    push_idle(3, 2'd3);
    step(3);
    chk("queue_drained", 32'(sb_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/scan_controller.md
Name: scan_controller

Overview:
- Time-multiplexes NUM_DIGITS hex digits onto one shared seven-segment segment bus and one-hot digit-select lines.
- Sequences the existing single-digit decode datapath (4-bit value to 8-bit segment pattern) across the digit positions, with an anti-ghosting blank gap between digits.
- Sits between the value-producing logic (counters, ALU results) and the board seven-segment pins.
- Takes a coherent snapshot of all digits once per frame, so the display never tears.

Parameters:
- NUM_DIGITS, 4: number of digit positions, 1..8.
- ON_CYCLES, 100000: clock cycles each digit is driven; minimum 1.
- BLANK_CYCLES, 1000: clock cycles of all-off gap after each digit; 0 removes the gap.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- EN  input  1  display enable; sampled only at frame boundaries.
- DATA  input  4*NUM_DIGITS  packed digit values; DATA[3:0] is digit 0 (rightmost, least significant).
- DP_IN  input  NUM_DIGITS  decimal point per digit; bit i belongs to digit i.
- SCAN_OUT  output  NUM_DIGITS  one-hot digit select, active-high.
- SEG_OUT  output  8  SEG_OUT[6:0] is the decode pattern, SEG_OUT[7] is DP; active-high, all zeros = dark.
- DIGIT_IDX  output  clog2(NUM_DIGITS), min 1  index of the current or last-shown digit.
- FRAME_DONE  output  1  one-cycle pulse on the final cycle of a frame.

Behaviour:
- Reset (asynchronous, RST_N=0), effective immediately without a clock edge:
  - SCAN_OUT=0, SEG_OUT=0, DIGIT_IDX=0, FRAME_DONE=0.
  - State IDLE, timer=0, snapshot registers=0.
- All outputs are registered. Outputs change on the same edge as the state transition that defines them.
- States: IDLE, SHOW, BLANK.
- IDLE:
  - Outputs are 0.
  - If EN=1: capture DATA and DP_IN into the snapshot, set idx=0, enter SHOW.
  - Frame start latency is 1 cycle after EN is sampled high.
- SHOW:
  - SCAN_OUT = 1 << idx.
  - SEG_OUT = {snapDP[idx], decode(snapDATA[idx])}.
  - The state is held for exactly ON_CYCLES cycles, then the block enters BLANK (or skips to the next digit when BLANK_CYCLES=0).
- BLANK:
  - SCAN_OUT=0, SEG_OUT=0, DIGIT_IDX unchanged.
  - The state is held for exactly BLANK_CYCLES cycles.
- Digit advance:
  - If idx < NUM_DIGITS-1: increment idx and enter SHOW.
  - If idx = NUM_DIGITS-1 (wrap): FRAME_DONE=1 for the last cycle of that digit's BLANK, or of its SHOW when BLANK_CYCLES=0.
  - At wrap, if EN=1: re-snapshot, set idx=0, enter SHOW.
  - At wrap, if EN=0: go to IDLE.
- Frame period is NUM_DIGITS*(ON_CYCLES+BLANK_CYCLES) cycles.
- DATA and DP_IN changes mid-frame are ignored until the next snapshot.
- EN falling mid-frame: the current frame completes, then the block goes IDLE.
- EN glitches that occur entirely within a frame have no effect.
- Timer is a down-counter of width clog2(max(ON_CYCLES,BLANK_CYCLES)+1). It is reloaded on every state entry.
- NUM_DIGITS=1: idx stays 0, and every digit period is also a frame end.
- Reset asserted mid-digit aborts immediately. After release, the next frame restarts at digit 0.

Optional Feature:
- Macro: SCAN_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit i > 0 is suppressed when snapDATA[i]=0, snapDP[i]=0, and every higher digit is also suppressed.
  - When suppressed, SEG_OUT=0 during its SHOW while SCAN_OUT still asserts, so timing is unchanged.
  - Digit 0 is never suppressed.
  - The suppression mask is computed once at snapshot.
- Undefined: every digit is always decoded. No mask logic is synthesised.

Decomposition:
- Package scan_pkg holds:
  - state enumeration (IDLE, SHOW, BLANK);
  - SEG_BLANK = 8'h00;
  - default ON_CYCLES and BLANK_CYCLES;
  - a function computing the digit index width.
- One natural sub-module: scan_timer, a loadable down-counter with a terminal-count output.
- The existing decode module is instantiated once, on the muxed snapshot nibble.

Test Plan (NUM_DIGITS=4, ON_CYCLES=4, BLANK_CYCLES=1 unless noted):
1. Basic scan:
   - Stimulus: reset, then EN=1, DATA=16'h1234, DP_IN=0.
   - Required: SCAN_OUT shows 0001×4, 0000×1, 0010×4, 0000×1, 0100×4, 0000×1, 1000×4, 0000×1.
   - Required: SEG_OUT is decode(4), decode(3), decode(2), decode(1) in the SHOW slots.
   - Required: FRAME_DONE is high on cycle 20 only, and the sequence repeats.
2. Coherent snapshot:
   - Stimulus: DATA changes 16'h1234→16'hABCD at frame cycle 7.
   - Required: the rest of the frame shows 2 and 1 for digits 2 and 3; the next frame shows D, C, B, A.
3. Disable:
   - Stimulus: EN=0 at frame cycle 10.
   - Required: the frame finishes with FRAME_DONE at cycle 20, then SCAN_OUT=0 and SEG_OUT=0 while IDLE.
   - Required: EN=1 restarts at SCAN_OUT=0001 one cycle later.
4. Async reset:
   - Stimulus: RST_N low between clock edges during digit 2.
   - Required: all outputs go to 0 before the next edge.
   - Required: after release with EN=1, the next frame begins at digit 0.
5. Decimal point:
   - Stimulus: DP_IN=4'b0100.
   - Required: SEG_OUT[7]=1 only while SCAN_OUT=0100, and 0 during BLANK.
6. Macro on, DATA=16'h0070:
   - Required: digits 3 and 2 give SEG_OUT=0 with SCAN_OUT asserted; digit 1 gives decode(7); digit 0 gives decode(0).
   - Required with the macro off: all four digits are decoded.
